// File: rtl/present_sbox_layer.sv
// Multi-cycle PRESENT substitution layer: applies the forward or inverse 4-bit
// S-box to every nibble of the state, LANES nibbles per clock, behind valid/ready.
module present_sbox_layer #(
  parameter int STATE_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               inv_i,
  input  logic [STATE_W-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [STATE_W-1:0] data_o
);

  localparam int NIBS  = STATE_W / 4;
  localparam int BEATS = STATE_W / (4 * LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Tables packed with nibble 0 in bits 3:0.
  localparam logic [63:0] FWD_TBL = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_TBL = 64'hA970364BD21C8FE5;

  if (LANES < 1 || (STATE_W % (4 * LANES)) != 0) begin : g_bad_params
    $error("present_sbox_layer: STATE_W must be a multiple of 4*LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [STATE_W-1:0] st, st_sub;
  logic               mode;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
    logic [63:0] tbl;
    tbl = inv ? INV_TBL : FWD_TBL;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  // Each nibble belongs to a fixed beat, so the lane muxing reduces to a
  // per-nibble compare against the beat counter.
  always_comb begin
    st_sub = st;
    for (int n = 0; n < NIBS; n++) begin
      if (cnt == CNT_W'(n / LANES)) st_sub[n*4 +: 4] = sbox(st[n*4 +: 4], mode);
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nx = BUSY;
      end
      BUSY: if (cnt == LAST_BEAT) state_nx = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      st    <= '0;
      mode  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (valid_i) begin
          st   <= data_i;
          mode <= inv_i;
          cnt  <= '0;
        end
        BUSY: begin
          st  <= st_sub;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_o = st;

endmodule

// File: tb/tb_present_sbox_layer.sv
// Directed bench for present_sbox_layer: default, LANES=16, LANES=1 and a
// 128-bit instance, checking latency, data, backpressure, reset and ordering.
module tb_present_sbox_layer;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         valid_i, valid_v, inv_i, ready_i;
  logic [63:0]  data_i;
  logic [127:0] data_w;

  logic         ready_o, valid_o, ready_16, valid_16, ready_1, valid_1, ready_w, valid_w;
  logic [63:0]  data_o, data_16, data_1;
  logic [127:0] data_wo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  present_sbox_layer #(.STATE_W(64), .LANES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o), .inv_i(inv_i),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o));

  present_sbox_layer #(.STATE_W(64), .LANES(16)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_v), .ready_o(ready_16), .inv_i(inv_i),
    .data_i(data_i), .valid_o(valid_16), .ready_i(ready_i), .data_o(data_16));

  present_sbox_layer #(.STATE_W(64), .LANES(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_v), .ready_o(ready_1), .inv_i(inv_i),
    .data_i(data_i), .valid_o(valid_1), .ready_i(ready_i), .data_o(data_1));

  present_sbox_layer #(.STATE_W(128), .LANES(4)) dutw (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_v), .ready_o(ready_w), .inv_i(inv_i),
    .data_i(data_w), .valid_o(valid_w), .ready_i(ready_i), .data_o(data_wo));

  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int nibs);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < nibs; n++) r[n*4 +: 4] = inv ? inv_t[d[n*4 +: 4]] : fwd_t[d[n*4 +: 4]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on the default instance with ready_i=1; inv_i and data_i
  // are scrambled while busy to show they are only sampled at acceptance.
  task automatic main_txn(input string tag, input logic [63:0] d, input logic inv,
                          input logic [63:0] exp);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, ready_o, 1'b1);
    valid_i = 1'b1; data_i = d; inv_i = inv; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; inv_i = ~inv; data_i = ~d;
    lat = 0;
    while (!valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_data"}, data_o, exp);
    @(negedge clk);
    check({tag, "_pulse"}, valid_o, 1'b0);
    check({tag, "_ready_after"}, ready_o, 1'b1);
  endtask

  // One transaction issued to the three variant instances together.
  task automatic variant_txn(input string tag, input logic [63:0] d, input logic [127:0] dw,
                             input logic inv);
    int lat16, lat1, latw;
    logic [63:0]  cap16, cap1;
    logic [127:0] capw;
    lat16 = 0; lat1 = 0; latw = 0; cap16 = '0; cap1 = '0; capw = '0;
    @(negedge clk);
    valid_v = 1'b1; data_i = d; data_w = dw; inv_i = inv; ready_i = 1'b1;
    @(negedge clk);
    valid_v = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (valid_16 && lat16 == 0) begin lat16 = k; cap16 = data_16; end
      if (valid_1  && lat1  == 0) begin lat1  = k; cap1  = data_1;  end
      if (valid_w  && latw  == 0) begin latw  = k; capw  = data_wo; end
    end
    check({tag, "_l16_latency"}, lat16, 1);
    check({tag, "_l16_data"}, cap16, model({64'h0, d}, inv, 16));
    check({tag, "_l1_latency"}, lat1, 16);
    check({tag, "_l1_data"}, cap1, model({64'h0, d}, inv, 16));
    check({tag, "_w128_latency"}, latw, 8);
    check({tag, "_w128_data"}, capw, model(dw, inv, 32));
  endtask

  initial begin
    logic [63:0] held, vec [8];
    logic [63:0] q [$];
    logic [63:0] expv;
    int idx, outn, cyc, lat;

    rst_n_i = 1'b0; valid_i = 1'b0; valid_v = 1'b0; inv_i = 1'b0; ready_i = 1'b1;
    data_i = '0; data_w = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", ready_o, 1'b1);
    check("reset_valid", valid_o, 1'b0);
    check("reset_data", data_o, 64'h0);
    rst_n_i = 1'b1;

    main_txn("fwd", 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712);
    main_txn("inv", 64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF);
    main_txn("zero", 64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC);
    main_txn("ones_inv", 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hAAAAAAAAAAAAAAAA);

    // Backpressure: result held for 10 cycles while a new offer is ignored.
    @(negedge clk);
    valid_i = 1'b1; data_i = 64'hFEDCBA9876543210; inv_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 4);
    held = data_o;
    check("bp_data", held, 64'h21748FE3DA09B65C);
    valid_i = 1'b1; data_i = 64'h1111111111111111; inv_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", valid_o, 1'b1);
      check("bp_data_hold", data_o, held);
      check("bp_ready_low", ready_o, 1'b0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_valid", valid_o, 1'b0);
    check("bp_release_ready", ready_o, 1'b1);
    check("bp_no_accept", data_o, held);

    // Reset landing on the edge that would process beat 2.
    @(negedge clk);
    valid_i = 1'b1; data_i = 64'h0123456789ABCDEF; inv_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, 64'h0);
    repeat (6) @(negedge clk);
    check("rst_no_stale_valid", valid_o, 1'b0);
    main_txn("post_rst", 64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712);

    // Parameter variants: directed then random states.
    variant_txn("var_dir", 64'h0123456789ABCDEF,
                {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 1'b0);
    check("var_w128_hand", data_wo, {64'hC56B90AD3EF84712, 64'h21748FE3DA09B65C});
    for (int i = 0; i < 3; i++) begin
      variant_txn("var_rnd", {$urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, i[0]);
    end

    // Back-to-back offers with random downstream readiness.
    for (int i = 0; i < 8; i++) vec[i] = {$urandom, $urandom};
    idx = 0; outn = 0; cyc = 0;
    while (outn < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (valid_o) check("b2b_no_overlap", ready_o, 1'b0);
      ready_i = 1'($urandom_range(0, 1));
      if (valid_o && ready_i) begin
        expv = (q.size() > 0) ? q.pop_front() : 64'hx;
        check("b2b_data", data_o, expv);
        outn++;
      end
      if (idx < 8) begin
        valid_i = 1'b1; data_i = vec[idx]; inv_i = (idx % 2 == 1);
        if (ready_o) begin
          q.push_back(model({64'h0, vec[idx]}, (idx % 2 == 1), 16));
          idx++;
        end
      end else begin
        valid_i = 1'b0;
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("b2b_count", outn, 8);
    check("b2b_accepted", idx, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
